// File: rtl/alu_exec_unit.sv
// alu_exec_unit: sequential ALU around a small register file.
// Each request runs IDLE -> FETCH -> EXEC -> WB -> DONE -> IDLE.
// Optional feature macro: ALU_EXEC_CHAIN_EN (ADC takes the stored carry as
// carry-in). When it is undefined, OP=7 behaves exactly like ADD.
//
// Handshake: START is a request qualified only in IDLE; the edge that sees
// START=1 in IDLE accepts the request and latches OP/A_ADDR/B_ADDR/C_ADDR.
// BUSY is high while the request is in flight (FETCH, EXEC, WB), and DONE is
// a one-cycle completion strobe. START outside IDLE is dropped, not queued.
module alu_exec_unit #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [2:0]        OP,
    input  logic [AWIDTH-1:0] A_ADDR,
    input  logic [AWIDTH-1:0] B_ADDR,
    input  logic [AWIDTH-1:0] C_ADDR,
    input  logic              LD_WE,
    input  logic [AWIDTH-1:0] LD_ADDR,
    input  logic [WIDTH-1:0]  LD_DIN,
    input  logic [AWIDTH-1:0] RD_ADDR,
    output logic [WIDTH-1:0]  RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [WIDTH-1:0]  RESULT,
    output logic              CARRY_OUT,
    output logic              ZERO_OUT,
    output logic [2:0]        FSM_STATE
);

    localparam int DEPTH = 1 << AWIDTH;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOTA = 3'd5;
    localparam logic [2:0] OP_PASB = 3'd6;
    localparam logic [2:0] OP_ADC  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]  regs [DEPTH];

    logic [2:0]        op_q;
    logic [AWIDTH-1:0] a_addr_q;
    logic [AWIDTH-1:0] b_addr_q;
    logic [AWIDTH-1:0] c_addr_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;

    logic              cin;
    logic [WIDTH:0]    add_full;
    logic [WIDTH:0]    adc_full;
    logic [WIDTH:0]    sub_full;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic              ld_open;

    // Carry-in for ADC: stored carry when chaining is built in, else zero.
`ifdef ALU_EXEC_CHAIN_EN
    assign cin = CARRY_OUT;
`else
    assign cin = 1'b0;
`endif

    // External loads are only accepted while no operation is in flight.
    assign ld_open = (state == S_IDLE) || (state == S_DONE);

    assign FSM_STATE = state;

    // Observation port reads the array directly, no clocking.
    assign RD_DATA = regs[RD_ADDR];

    // State register; reset overrides any in-flight operation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode; exactly one cycle per state.
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                BUSY      = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                BUSY      = 1'b1;
                state_nxt = S_WB;
            end
            S_WB: begin
                BUSY      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request fields on the accepting edge only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q     <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
        end else if ((state == S_IDLE) && START) begin
            op_q     <= OP;
            a_addr_q <= A_ADDR;
            b_addr_q <= B_ADDR;
            c_addr_q <= C_ADDR;
        end
    end

    // Operand fetch; reads happen before any write-back of this operation,
    // so A, B and C may all name the same register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q <= '0;
            b_q <= '0;
        end else if (state == S_FETCH) begin
            a_q <= regs[a_addr_q];
            b_q <= regs[b_addr_q];
        end
    end

    // Wide adders: bit WIDTH is the carry (ADD/ADC) or the borrow (SUB).
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign adc_full = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    assign sub_full = {1'b0, a_q} - {1'b0, b_q};

    // Operation select; logic ops leave the carry cleared.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  {alu_carry, alu_res} = add_full;
            OP_SUB:  {alu_carry, alu_res} = sub_full;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOTA: alu_res = ~a_q;
            OP_PASB: alu_res = b_q;
            OP_ADC:  {alu_carry, alu_res} = adc_full;
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // Result and flags update only at the EXEC edge and hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT    <= '0;
            CARRY_OUT <= 1'b0;
            ZERO_OUT  <= 1'b0;
        end else if (state == S_EXEC) begin
            RESULT    <= alu_res;
            CARRY_OUT <= alu_carry;
            ZERO_OUT  <= (alu_res == '0);
        end
    end

    // Register file: write-back in WB, external loads in IDLE/DONE only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_WB) begin
            regs[c_addr_q] <= RESULT;
        end else if (LD_WE && ld_open) begin
            regs[LD_ADDR] <= LD_DIN;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=8, AWIDTH=2).
// Expected values are hand-computed constants; ALU_EXEC_CHAIN_EN selects
// the expected ADC outcome.
module tb_alu_exec_unit;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [2:0] OP;
    logic [1:0] A_ADDR;
    logic [1:0] B_ADDR;
    logic [1:0] C_ADDR;
    logic       LD_WE;
    logic [1:0] LD_ADDR;
    logic [7:0] LD_DIN;
    logic [1:0] RD_ADDR;
    logic [7:0] RD_DATA;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;
    logic       CARRY_OUT;
    logic       ZERO_OUT;
    logic [2:0] FSM_STATE;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_adc;
    logic       exp_adc_zero;

    alu_exec_unit #(.WIDTH(8), .AWIDTH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .OP        (OP),
        .A_ADDR    (A_ADDR),
        .B_ADDR    (B_ADDR),
        .C_ADDR    (C_ADDR),
        .LD_WE     (LD_WE),
        .LD_ADDR   (LD_ADDR),
        .LD_DIN    (LD_DIN),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .CARRY_OUT (CARRY_OUT),
        .ZERO_OUT  (ZERO_OUT),
        .FSM_STATE (FSM_STATE)
    );

    // Clock: 10 time-unit period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        RD_ADDR = addr;
        #1;
        check(tag, {8'h00, RD_DATA}, {8'h00, exp});
    endtask

    task automatic load(input logic [1:0] addr, input logic [7:0] din);
        @(negedge CLK);
        LD_WE   = 1'b1;
        LD_ADDR = addr;
        LD_DIN  = din;
        @(negedge CLK);
        LD_WE   = 1'b0;
    endtask

    // Issue one operation (optionally with a coincident load) and wait for
    // DONE with a bounded cycle budget; checks BUSY and a 4-edge latency.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] a,
                          input logic [1:0] b, input logic [1:0] c, input logic ld_en,
                          input logic [1:0] ld_addr, input logic [7:0] ld_din);
        int  n;
        bit  got;
        @(negedge CLK);
        OP      = op;
        A_ADDR  = a;
        B_ADDR  = b;
        C_ADDR  = c;
        START   = 1'b1;
        LD_WE   = ld_en;
        LD_ADDR = ld_addr;
        LD_DIN  = ld_din;
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge CLK);
            @(negedge CLK);
            START = 1'b0;
            LD_WE = 1'b0;
            n++;
            if (DONE) begin
                got = 1'b1;
            end else begin
                check({tag, " busy"}, {15'd0, BUSY}, 16'd1);
            end
        end
        check({tag, " latency"}, n[15:0], 16'd4);
        @(posedge CLK);
        @(negedge CLK);
        check({tag, " done drop"}, {15'd0, DONE}, 16'd0);
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic cy, input logic z);
        check({tag, " result"}, {8'h00, RESULT}, {8'h00, res});
        check({tag, " carry"}, {15'd0, CARRY_OUT}, {15'd0, cy});
        check({tag, " zero"}, {15'd0, ZERO_OUT}, {15'd0, z});
    endtask

    initial begin
        int pulses;

`ifdef ALU_EXEC_CHAIN_EN
        exp_adc      = 8'h01;
        exp_adc_zero = 1'b0;
`else
        exp_adc      = 8'h00;
        exp_adc_zero = 1'b1;
`endif

        RST = 1'b1; START = 1'b0; OP = 3'd0;
        A_ADDR = 2'd0; B_ADDR = 2'd0; C_ADDR = 2'd0;
        LD_WE = 1'b0; LD_ADDR = 2'd0; LD_DIN = 8'h00; RD_ADDR = 2'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Reset state.
        check("rst state", {13'd0, FSM_STATE}, 16'd0);
        check("rst busy", {15'd0, BUSY}, 16'd0);
        check("rst done", {15'd0, DONE}, 16'd0);
        check_out("rst", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_reg("rst reg", i[1:0], 8'h00);

        // ADD 0xC8 + 0x64 = 0x12C.
        load(2'd0, 8'hC8);
        load(2'd1, 8'h64);
        run_op("add", 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_out("add", 8'h2C, 1'b1, 1'b0);
        check_reg("add r2", 2'd2, 8'h2C);

        // SUB 0x05 - 0x07 borrows; SUB 0x07 - 0x05 does not.
        load(2'd0, 8'h05);
        load(2'd1, 8'h07);
        run_op("sub1", 3'd1, 2'd0, 2'd1, 2'd3, 1'b0, 2'd0, 8'h00);
        check_out("sub1", 8'hFE, 1'b1, 1'b0);
        check_reg("sub1 r3", 2'd3, 8'hFE);
        run_op("sub2", 3'd1, 2'd1, 2'd0, 2'd2, 1'b0, 2'd0, 8'h00);
        check_out("sub2", 8'h02, 1'b0, 1'b0);
        check_reg("sub2 r2", 2'd2, 8'h02);

        // Outputs hold while idle.
        repeat (5) @(negedge CLK);
        check_out("hold", 8'h02, 1'b0, 1'b0);

        // XOR with A=B=C=1 reads before overwrite.
        load(2'd1, 8'h5A);
        run_op("xor", 3'd4, 2'd1, 2'd1, 2'd1, 1'b0, 2'd0, 8'h00);
        check_out("xor", 8'h00, 1'b0, 1'b1);
        check_reg("xor r1", 2'd1, 8'h00);

        // ADD leaving carry, then ADC 0 + 0.
        load(2'd0, 8'hFF);
        load(2'd1, 8'h01);
        run_op("addc", 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_out("addc", 8'h00, 1'b1, 1'b1);
        run_op("adc", 3'd7, 2'd2, 2'd2, 2'd3, 1'b0, 2'd0, 8'h00);
        check_out("adc", exp_adc, 1'b0, exp_adc_zero);
        check_reg("adc r3", 2'd3, exp_adc);

        // Logic ops clear a previously set carry.
        load(2'd0, 8'hC3);
        load(2'd1, 8'h5A);
        run_op("add2", 3'd0, 2'd0, 2'd1, 2'd3, 1'b0, 2'd0, 8'h00);
        check_out("add2", 8'h1D, 1'b1, 1'b0);
        run_op("and", 3'd2, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_out("and", 8'h42, 1'b0, 1'b0);
        run_op("or", 3'd3, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_out("or", 8'hDB, 1'b0, 1'b0);
        run_op("nota", 3'd5, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_out("nota", 8'h3C, 1'b0, 1'b0);
        run_op("passb", 3'd6, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
        check_out("passb", 8'h5A, 1'b0, 1'b0);
        check_reg("passb r2", 2'd2, 8'h5A);

        // START and LD_WE pulsed in EXEC are both dropped.
        @(negedge CLK);
        OP = 3'd0; A_ADDR = 2'd0; B_ADDR = 2'd1; C_ADDR = 2'd2;
        START = 1'b1;
        pulses = 0;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("exec state", {13'd0, FSM_STATE}, 16'd2);
        START = 1'b1; OP = 3'd1; LD_WE = 1'b1; LD_ADDR = 2'd0; LD_DIN = 8'h77;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            START = 1'b0;
            LD_WE = 1'b0;
            if (DONE) pulses++;
        end
        check("ignore pulses", pulses[15:0], 16'd1);
        check("ignore busy", {15'd0, BUSY}, 16'd0);
        check_out("ignore", 8'h1D, 1'b1, 1'b0);
        check_reg("ignore r0", 2'd0, 8'hC3);
        check_reg("ignore r2", 2'd2, 8'h1D);

        // Load coincident with START is seen by FETCH: 0x10 + 0x5A.
        run_op("ldst", 3'd0, 2'd0, 2'd1, 2'd3, 1'b1, 2'd0, 8'h10);
        check_out("ldst", 8'h6A, 1'b0, 1'b0);
        check_reg("ldst r0", 2'd0, 8'h10);
        check_reg("ldst r3", 2'd3, 8'h6A);

        // Reset in EXEC aborts with no write-back and clears everything.
        load(2'd2, 8'hAA);
        @(negedge CLK);
        OP = 3'd0; A_ADDR = 2'd0; B_ADDR = 2'd1; C_ADDR = 2'd2;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("abort exec", {13'd0, FSM_STATE}, 16'd2);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("abort state", {13'd0, FSM_STATE}, 16'd0);
        check("abort busy", {15'd0, BUSY}, 16'd0);
        check("abort done", {15'd0, DONE}, 16'd0);
        check_out("abort", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_reg("abort reg", i[1:0], 8'h00);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE) pulses++;
        end
        check("abort no done", pulses[15:0], 16'd0);
        check_reg("abort r2 late", 2'd2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width, legal range 2 to 16.
REQ-002 SHALL have parameter AWIDTH, default 2: register-file address width, holding 2^AWIDTH words.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port START, input, 1: operation request, sampled only in IDLE.
REQ-006 SHALL have port OP, input, 3: opcode 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS B, 7 ADC.
REQ-007 SHALL have ports A_ADDR, B_ADDR and C_ADDR, input, AWIDTH each: operand A, operand B and destination addresses.
REQ-008 SHALL have ports LD_WE (input, 1), LD_ADDR (input, AWIDTH) and LD_DIN (input, WIDTH): external register load.
REQ-009 SHALL have ports RD_ADDR (input, AWIDTH) and RD_DATA (output, WIDTH): asynchronous observation read of the register file.
REQ-010 SHALL have outputs BUSY (1), DONE (1), RESULT (WIDTH), CARRY_OUT (1) and ZERO_OUT (1).

Function
REQ-011 SHALL implement the FSM IDLE -> FETCH -> EXEC -> WB -> DONE -> IDLE, with one cycle per state.
REQ-012 SHALL leave IDLE only on an edge with START=1, latching OP, A_ADDR, B_ADDR and C_ADDR at that edge.
REQ-013 SHALL latch operands reg[A] and reg[B] at the FETCH edge.
REQ-014 SHALL, at the EXEC edge, register RESULT and update the flags.
REQ-015 SHALL write RESULT to reg[C] at the WB edge.
REQ-016 SHALL drive BUSY=1 in FETCH, EXEC and WB.
REQ-017 SHALL drive DONE=1 for exactly one cycle, in the DONE state.
REQ-018 SHALL give a latency of 4 edges from the START-sampling edge to DONE being high.
REQ-019 SHALL ignore START in every state other than IDLE; requests are neither queued nor counted.
REQ-020 SHALL compute arithmetic modulo 2^WIDTH.
REQ-021 SHALL set CARRY_OUT to bit WIDTH of A+B for ADD and of A+B+Cin for ADC.
REQ-022 SHALL, for SUB, produce RESULT = A-B and CARRY_OUT = borrow (1 when A<B).
REQ-023 SHALL clear CARRY_OUT for ops 2 to 6.
REQ-024 SHALL set ZERO_OUT to 1 exactly when the new RESULT equals 0.
REQ-025 SHALL hold RESULT, CARRY_OUT and ZERO_OUT between operations.
REQ-026 SHALL perform an LD_WE write only in IDLE or DONE; LD_WE is ignored in FETCH, EXEC and WB.
REQ-027 SHALL, when LD_WE and START coincide in IDLE, perform the load at that edge, so FETCH sees the loaded value.
REQ-028 SHALL allow A_ADDR=B_ADDR=C_ADDR; operands are read at FETCH, before the WB overwrite.
REQ-029 SHALL drive RD_DATA = reg[RD_ADDR] combinationally, reflecting a WB or LD write from the cycle after that write.

Reset
REQ-030 SHALL, on an edge with RST=1, enter IDLE and clear every register-file word, RESULT, CARRY_OUT, ZERO_OUT, BUSY and DONE to 0.
REQ-031 SHALL give RST priority over START, LD_WE and any in-flight state.
REQ-032 SHALL abort an operation when RST is asserted in FETCH, EXEC or WB, with no WB write.

Configuration
REQ-033 SHALL, with macro ALU_EXEC_CHAIN_EN defined, make ADC use the stored CARRY_OUT as Cin, enabling multi-word add chains.
REQ-034 SHALL, without ALU_EXEC_CHAIN_EN, execute OP=7 exactly as ADD (Cin=0).

Verification
REQ-035 SHALL cover: load r0=0xC8, r1=0x64, ADD A=0,B=1,C=2 -> DONE 4 edges after START, r2=0x2C, CARRY_OUT=1, ZERO_OUT=0.
REQ-036 SHALL cover: with r0=0x05, r1=0x07, SUB C=3 -> r3=0xFE, CARRY_OUT=1; then SUB r1-r0 -> 0x02, CARRY_OUT=0.
REQ-037 SHALL cover: XOR with A=B=C=1 (r1=0x5A) -> r1=0x00, ZERO_OUT=1, CARRY_OUT=0.
REQ-038 SHALL cover: after an ADD leaving CARRY_OUT=1, ADC of 0x00+0x00 -> 0x01 with ALU_EXEC_CHAIN_EN defined, 0x00 without.
REQ-039 SHALL cover: START and LD_WE pulsed during EXEC -> both ignored, single DONE pulse, target register unchanged.
REQ-040 SHALL cover: RST in EXEC -> IDLE next cycle, no DONE, all registers and outputs 0, RD_DATA=0 for every address.
